// File: rtl/s2qed_wb_checker.sv
// S2QED writeback checker: pairs core 0/1 register writebacks in program order and latches the
// first data/rd-map divergence, FIFO overflow or skew timeout. Optional macro: S2QED_WB_RDCHECK_EN.

module s2qed_wb_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic         empty,
   output logic         full
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wp, rp;

   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
      end
   end

   // A push into a full FIFO is only issued alongside a pop, so overwriting the head slot is safe.
   always_ff @(posedge clk)
      if (push && !rst) mem[wp[AW-1:0]] <= din;

   assign head  = mem[rp[AW-1:0]];
   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

module s2qed_wb_checker #(
   parameter int DEPTH    = 8,
   parameter int MAX_SKEW = 64,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu0_wb_valid,
   input  logic [4:0]       cpu0_wb_rd,
   input  logic [31:0]      cpu0_wb_data,
   input  logic             cpu1_wb_valid,
   input  logic [4:0]       cpu1_wb_rd,
   input  logic [31:0]      cpu1_wb_data,
   output logic [CNT_W-1:0] match_cnt,
   output logic             fail,
   output logic [2:0]       fail_code,
   output logic [31:0]      fail_data0,
   output logic [31:0]      fail_data1
);
`ifdef S2QED_WB_RDCHECK_EN
   localparam int EW = 37;
`else
   localparam int EW = 32;
`endif
   localparam int            SW        = $clog2(MAX_SKEW + 1);
   localparam logic [SW-1:0] SKEW_LAST = SW'(MAX_SKEW - 1);

   typedef enum logic {ST_RUN, ST_FAIL} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] match_q, match_d;
   logic [SW-1:0]    skew_q, skew_d;
   logic [2:0]       code_q, code_d;
   logic [31:0]      d0_q, d0_d, d1_q, d1_d;

   logic [1:0]         wb_valid, want, push, empty, full;
   logic [1:0][4:0]    wb_rd;
   logic [1:0][EW-1:0] entry, head;
   logic               run, pop, pop_ok, ovf, rd_bad, data_bad, one_busy, skew_to, fail_now;

   assign wb_valid = {cpu1_wb_valid, cpu0_wb_valid};
   assign wb_rd    = {cpu1_wb_rd, cpu0_wb_rd};
`ifdef S2QED_WB_RDCHECK_EN
   assign entry = {{cpu1_wb_rd, cpu1_wb_data}, {cpu0_wb_rd, cpu0_wb_data}};
`else
   assign entry = {cpu1_wb_data, cpu0_wb_data};
`endif

   genvar g;
   generate
      for (g = 0; g < 2; g++) begin : g_core
         s2qed_wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .pop   (pop_ok),
            .din   (entry[g]),
            .head  (head[g]),
            .empty (empty[g]),
            .full  (full[g])
         );
      end
   endgenerate

   assign run      = (state_q == ST_RUN);
   assign want     = wb_valid & {wb_rd[1] != 5'd0, wb_rd[0] != 5'd0} & {2{run}};
   assign pop      = run && !empty[0] && !empty[1];
   assign ovf      = |(want & full) && !pop;
   assign data_bad = pop && (head[0][31:0] != head[1][31:0]);
   assign one_busy = empty[0] ^ empty[1];
   assign skew_to  = run && one_busy && (skew_q == SKEW_LAST);

`ifdef S2QED_WB_RDCHECK_EN
   // 44-rd is taken modulo 32 (as 12-rd) since the result always fits in 5 bits.
   function automatic logic [4:0] rd_map(input logic [4:0] rd);
      if (rd == 5'd0)       return 5'd0;
      else if (rd <= 5'd12) return 5'd13 - rd;
      else                  return 5'd12 - rd;
   endfunction
   assign rd_bad = pop && (head[1][36:32] != rd_map(head[0][36:32]));
`else
   assign rd_bad = 1'b0;
`endif

   assign fail_now = ovf || rd_bad || data_bad || skew_to;
   assign pop_ok   = pop && !fail_now;
   assign push     = want & {2{~fail_now}};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         match_q <= '0;
         skew_q  <= '0;
         code_q  <= 3'd0;
         d0_q    <= '0;
         d1_q    <= '0;
      end else begin
         state_q <= state_d;
         match_q <= match_d;
         skew_q  <= skew_d;
         code_q  <= code_d;
         d0_q    <= d0_d;
         d1_q    <= d1_d;
      end
   end

   always_comb begin
      state_d = state_q;
      match_d = match_q;
      skew_d  = skew_q;
      code_d  = code_q;
      d0_d    = d0_q;
      d1_d    = d1_q;
      if (run) begin
         if (fail_now) begin
            state_d = ST_FAIL;
            d0_d    = '0;
            d1_d    = '0;
            if (ovf) code_d = 3'd3;
            else if (rd_bad || data_bad) begin
               code_d = rd_bad ? 3'd2 : 3'd1;
               d0_d   = head[0][31:0];
               d1_d   = head[1][31:0];
            end else code_d = 3'd4;
         end else if (pop) begin
            skew_d = '0;
            if (match_q != '1) match_d = match_q + 1'b1;
         end else if (one_busy) begin
            skew_d = skew_q + 1'b1;
         end else begin
            skew_d = '0;
         end
      end
   end

   assign match_cnt  = match_q;
   assign fail       = (state_q == ST_FAIL);
   assign fail_code  = code_q;
   assign fail_data0 = d0_q;
   assign fail_data1 = d1_q;
endmodule

// File: tb/tb_s2qed_wb_checker.sv
// Bench for s2qed_wb_checker: directed scenarios plus random paired streams checked against a queue model.

module tb_s2qed_wb_checker;
   localparam int DEPTH    = 8;
   localparam int MAX_SKEW = 64;
   localparam int CNT_W    = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cpu0_wb_valid = 1'b0, cpu1_wb_valid = 1'b0;
   logic [4:0]       cpu0_wb_rd = '0, cpu1_wb_rd = '0;
   logic [31:0]      cpu0_wb_data = '0, cpu1_wb_data = '0;
   logic [CNT_W-1:0] match_cnt;
   logic             fail;
   logic [2:0]       fail_code;
   logic [31:0]      fail_data0, fail_data1;

   int tests  = 0;
   int errors = 0;

   always #5 clk = ~clk;

   s2qed_wb_checker #(.DEPTH(DEPTH), .MAX_SKEW(MAX_SKEW), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .cpu0_wb_valid (cpu0_wb_valid),
      .cpu0_wb_rd    (cpu0_wb_rd),
      .cpu0_wb_data  (cpu0_wb_data),
      .cpu1_wb_valid (cpu1_wb_valid),
      .cpu1_wb_rd    (cpu1_wb_rd),
      .cpu1_wb_data  (cpu1_wb_data),
      .match_cnt     (match_cnt),
      .fail          (fail),
      .fail_code     (fail_code),
      .fail_data0    (fail_data0),
      .fail_data1    (fail_data1)
   );

   // Reference model: two program-order queues and the checker's visible state.
   logic [36:0] m_q0[$], m_q1[$];
   int          m_match, m_skew, m_code;
   bit          m_fail;
   logic [31:0] m_d0, m_d1;

   function automatic int exp_map(input int rd);
      if (rd == 0) return 0;
      if (rd <= 12) return 13 - rd;
      return 44 - rd;
   endfunction

   task automatic model_step(input bit r, input bit v0, input int r0, input logic [31:0] x0,
                             input bit v1, input int r1, input logic [31:0] x1);
      bit pop, ovf, rdb, dtb, one, tout;
      if (r) begin
         m_q0.delete(); m_q1.delete();
         m_match = 0; m_skew = 0; m_code = 0; m_fail = 0; m_d0 = '0; m_d1 = '0;
         return;
      end
      if (m_fail) return;
      pop = (m_q0.size() != 0) && (m_q1.size() != 0);
      ovf = ((v0 && r0 != 0 && m_q0.size() == DEPTH) || (v1 && r1 != 0 && m_q1.size() == DEPTH)) && !pop;
      rdb = 0;
      dtb = 0;
      if (pop) begin
`ifdef S2QED_WB_RDCHECK_EN
         rdb = int'(m_q1[0][36:32]) != exp_map(int'(m_q0[0][36:32]));
`endif
         dtb = m_q0[0][31:0] != m_q1[0][31:0];
      end
      one  = (m_q0.size() == 0) != (m_q1.size() == 0);
      tout = one && (m_skew + 1 >= MAX_SKEW);
      if (ovf || rdb || dtb || tout) begin
         m_fail = 1;
         m_code = ovf ? 3 : rdb ? 2 : dtb ? 1 : 4;
         m_d0   = (!ovf && (rdb || dtb)) ? m_q0[0][31:0] : 32'h0;
         m_d1   = (!ovf && (rdb || dtb)) ? m_q1[0][31:0] : 32'h0;
         return;
      end
      if (pop) begin
         void'(m_q0.pop_front());
         void'(m_q1.pop_front());
         if (m_match < (2 ** CNT_W) - 1) m_match++;
         m_skew = 0;
      end else if (one) m_skew++;
      else m_skew = 0;
      if (v0 && r0 != 0) m_q0.push_back({r0[4:0], x0});
      if (v1 && r1 != 0) m_q1.push_back({r1[4:0], x1});
   endtask

   task automatic step(input bit r, input bit v0, input int r0, input logic [31:0] x0,
                       input bit v1, input int r1, input logic [31:0] x1);
      @(negedge clk);
      rst           = r;
      cpu0_wb_valid = v0;
      cpu0_wb_rd    = r0[4:0];
      cpu0_wb_data  = x0;
      cpu1_wb_valid = v1;
      cpu1_wb_rd    = r1[4:0];
      cpu1_wb_data  = x1;
      model_step(r, v0, r0, x0, v1, r1, x1);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      do_reset();
      idle(1);
      tests++; if (match_cnt !== '0) begin errors++; $display("FAIL reset match_cnt: got %0h want 0", match_cnt); end
      tests++; if (fail !== 1'b0) begin errors++; $display("FAIL reset fail: got %0b want 0", fail); end
      tests++; if (fail_code !== 3'd0) begin errors++; $display("FAIL reset fail_code: got %0d want 0", fail_code); end
      tests++; if ({fail_data0, fail_data1} !== 64'h0) begin errors++; $display("FAIL reset fail_data: got %h %h want 0 0", fail_data0, fail_data1); end
   endtask

   task automatic test_identical();
      step(0, 1, 1, 32'h5, 1, 12, 32'h5);
      tests++; if (match_cnt !== 16'd0) begin errors++; $display("FAIL ident latency: got %0d want 0", match_cnt); end
      step(0, 1, 13, 32'h7, 1, 31, 32'h7);
      tests++; if (match_cnt !== 16'd1) begin errors++; $display("FAIL ident first pair: got %0d want 1", match_cnt); end
      idle(1);
      tests++; if (match_cnt !== 16'd2) begin errors++; $display("FAIL ident match_cnt: got %0d want 2", match_cnt); end
      tests++; if (fail !== 1'b0) begin errors++; $display("FAIL ident fail: got %0b want 0", fail); end
   endtask

   task automatic test_data_mismatch();
      step(0, 1, 3, 32'hDEAD, 1, 10, 32'hBEEF);
      idle(1);
      tests++; if (fail !== 1'b1) begin errors++; $display("FAIL datamis fail: got %0b want 1", fail); end
      tests++; if (fail_code !== 3'd1) begin errors++; $display("FAIL datamis code: got %0d want 1", fail_code); end
      tests++; if (fail_data0 !== 32'hDEAD || fail_data1 !== 32'hBEEF) begin errors++; $display("FAIL datamis data: got %h %h want dead beef", fail_data0, fail_data1); end
      tests++; if (match_cnt !== 16'd2) begin errors++; $display("FAIL datamis match_cnt: got %0d want 2", match_cnt); end
   endtask

   task automatic test_sticky();
      for (int i = 1; i <= 6; i++) step(0, 1, i, 32'(i), 1, 13 - i, 32'(i));
      idle(2);
      tests++; if (match_cnt !== 16'd2) begin errors++; $display("FAIL sticky match_cnt: got %0d want 2", match_cnt); end
      tests++; if (fail !== 1'b1 || fail_code !== 3'd1) begin errors++; $display("FAIL sticky code: got %0b/%0d want 1/1", fail, fail_code); end
      tests++; if (fail_data0 !== 32'hDEAD || fail_data1 !== 32'hBEEF) begin errors++; $display("FAIL sticky data: got %h %h want dead beef", fail_data0, fail_data1); end
   endtask

   task automatic test_map_mismatch();
      do_reset();
      step(0, 1, 5, 32'h1, 1, 5, 32'h1);
      idle(1);
`ifdef S2QED_WB_RDCHECK_EN
      tests++; if (fail !== 1'b1 || fail_code !== 3'd2) begin errors++; $display("FAIL mapmis code: got %0b/%0d want 1/2", fail, fail_code); end
      tests++; if (fail_data0 !== 32'h1 || fail_data1 !== 32'h1) begin errors++; $display("FAIL mapmis data: got %h %h want 1 1", fail_data0, fail_data1); end
`else
      tests++; if (match_cnt !== 16'd1) begin errors++; $display("FAIL mapmis match_cnt: got %0d want 1", match_cnt); end
      tests++; if (fail !== 1'b0) begin errors++; $display("FAIL mapmis fail: got %0b want 0", fail); end
`endif
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 8; i++) step(0, 1, 1 + i, 32'(100 + i), 0, 0, 0);
      tests++; if (fail !== 1'b0) begin errors++; $display("FAIL ovf early: got %0b want 0 after 8 pushes", fail); end
      step(0, 1, 9, 32'h109, 0, 0, 0);
      tests++; if (fail !== 1'b1 || fail_code !== 3'd3) begin errors++; $display("FAIL ovf code: got %0b/%0d want 1/3", fail, fail_code); end
      tests++; if ({fail_data0, fail_data1} !== 64'h0) begin errors++; $display("FAIL ovf data: got %h %h want 0 0", fail_data0, fail_data1); end
   endtask

   task automatic test_skew();
      do_reset();
      step(0, 1, 7, 32'h77, 0, 0, 0);
      idle(MAX_SKEW - 1);
      tests++; if (fail !== 1'b0) begin errors++; $display("FAIL skew early: got %0b want 0", fail); end
      idle(1);
      tests++; if (fail !== 1'b1 || fail_code !== 3'd4) begin errors++; $display("FAIL skew code: got %0b/%0d want 1/4", fail, fail_code); end
      tests++; if ({fail_data0, fail_data1} !== 64'h0) begin errors++; $display("FAIL skew data: got %h %h want 0 0", fail_data0, fail_data1); end
   endtask

   task automatic test_x0_filter();
      do_reset();
      step(0, 1, 0, 32'h99, 0, 0, 0);
      idle(100);
      tests++; if (fail !== 1'b0) begin errors++; $display("FAIL x0 timeout: got fail=%0b code=%0d want 0", fail, fail_code); end
      step(0, 1, 2, 32'h11, 1, 11, 32'h11);
      idle(1);
      tests++; if (match_cnt !== 16'd1 || fail !== 1'b0) begin errors++; $display("FAIL x0 pair: got match=%0d fail=%0b want 1 0", match_cnt, fail); end
   endtask

   task automatic test_midrun_reset();
      do_reset();
      for (int i = 1; i <= 5; i++) step(0, 1, i, 32'(i * 3), 1, 13 - i, 32'(i * 3));
      for (int i = 1; i <= 3; i++) step(0, 1, i, 32'(i + 40), 0, 0, 0);
      tests++; if (match_cnt !== 16'd5) begin errors++; $display("FAIL midrst setup: got %0d want 5", match_cnt); end
      step(1, 1, 4, 32'hAA, 1, 9, 32'hAA);
      tests++; if (match_cnt !== '0 || fail !== 1'b0 || fail_code !== 3'd0) begin errors++; $display("FAIL midrst clear: got match=%0d fail=%0b code=%0d want 0", match_cnt, fail, fail_code); end
      tests++; if ({fail_data0, fail_data1} !== 64'h0) begin errors++; $display("FAIL midrst data: got %h %h want 0 0", fail_data0, fail_data1); end
      step(0, 1, 1, 32'h33, 1, 12, 32'h33);
      idle(1);
      tests++; if (match_cnt !== 16'd1 || fail !== 1'b0) begin errors++; $display("FAIL midrst fresh: got match=%0d fail=%0b want 1 0", match_cnt, fail); end
   endtask

   task automatic test_random();
      logic [36:0] ops[$];
      int          i0, i1, r0, r1;
      bit          v0, v1;
      logic [31:0] x0, x1;
      for (int e = 0; e < 5; e++) begin
         ops.delete();
         i0 = 0;
         i1 = 0;
         do_reset();
         for (int c = 0; c < 320; c++) begin
            v0 = ($urandom_range(0, 3) != 0) && (i0 - i1 < 9);
            v1 = ($urandom_range(0, 3) != 0) && (i1 - i0 < 9);
            r0 = 0; r1 = 0; x0 = '0; x1 = '0;
            if (v0) begin
               if (i0 == ops.size()) ops.push_back({5'($urandom_range(0, 31)), 32'($urandom)});
               r0 = int'(ops[i0][36:32]);
               x0 = ops[i0][31:0];
               i0++;
            end
            if (v1) begin
               if (i1 == ops.size()) ops.push_back({5'($urandom_range(0, 31)), 32'($urandom)});
               r1 = exp_map(int'(ops[i1][36:32]));
               x1 = ops[i1][31:0];
               i1++;
               if ($urandom_range(0, 299) == 0) x1 = x1 ^ 32'h1;
               if ($urandom_range(0, 299) == 0) r1 = (r1 % 31) + 1;
            end
            step(0, v0, r0, x0, v1, r1, x1);
            tests++;
            if ({match_cnt, fail, fail_code, fail_data0, fail_data1} !==
                {m_match[CNT_W-1:0], m_fail, m_code[2:0], m_d0, m_d1}) begin
               errors++;
               $display("FAIL random e%0d c%0d: got match=%0d fail=%0b code=%0d d0=%h d1=%h want match=%0d fail=%0b code=%0d d0=%h d1=%h",
                        e, c, match_cnt, fail, fail_code, fail_data0, fail_data1, m_match, m_fail, m_code, m_d0, m_d1);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_identical();
      test_data_mismatch();
      test_sticky();
      test_map_mismatch();
      test_overflow();
      test_skew();
      test_x0_filter();
      test_midrun_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
